// File: rtl/pic_tmr1_peripheral.sv
// pic_tmr1_peripheral: Timer1-style bus responder.
// 16-bit up-counter behind a 1:1/2/4/8 prescaler clocked by instr_tick,
// with a TMR1IF/TMR1IE pair and a registered interrupt request.
// Optional feature macro: TMR1_GATE_EN (T1CON.TMR1GE plus a synchronised
// active-low gate input t1g_n). Without it, TMR1GE reads 0 and t1g_n is unused.
module pic_tmr1_peripheral #(
  parameter logic [7:0] ADDR_TMR1L = 8'h0E,
  parameter logic [7:0] ADDR_TMR1H = 8'h0F,
  parameter logic [7:0] ADDR_T1CON = 8'h10,
  parameter logic [7:0] ADDR_PIR1  = 8'h0C,
  parameter logic [7:0] ADDR_PIE1  = 8'h8C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_tick,
  input  logic [7:0] addr,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       addr_hit,
  input  logic       t1g_n,
  output logic       tmr1_irq
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned PS_W  = 3;

  logic [CNT_W-1:0] r_tmr1;
  logic [PS_W-1:0]  r_presc;
  logic             r_ton;
  logic [1:0]       r_ckps;
  logic             r_if;
  logic             r_ie;
  logic             r_irq;

  logic             w_wr_l;
  logic             w_wr_h;
  logic             w_wr_con;
  logic             w_wr_pir;
  logic             w_wr_pie;
  logic             w_enabled;
  logic             w_ge_rd;
  logic [PS_W-1:0]  w_term;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PS_W-1:0]  w_presc_nxt;
  logic             w_ovf;

  assign w_wr_l   = wr_en && (addr == ADDR_TMR1L);
  assign w_wr_h   = wr_en && (addr == ADDR_TMR1H);
  assign w_wr_con = wr_en && (addr == ADDR_T1CON);
  assign w_wr_pir = wr_en && (addr == ADDR_PIR1);
  assign w_wr_pie = wr_en && (addr == ADDR_PIE1);

`ifdef TMR1_GATE_EN
  logic r_ge;
  logic r_gsync1;
  logic r_gsync2;

  // Gate enable bit and two-flop synchroniser for the asynchronous gate pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ge     <= 1'b0;
      r_gsync1 <= 1'b1;
      r_gsync2 <= 1'b1;
    end else begin
      if (w_wr_con) r_ge <= data_in[6];
      r_gsync1 <= t1g_n;
      r_gsync2 <= r_gsync1;
    end
  end

  assign w_enabled = r_ton && (!r_ge || !r_gsync2);
  assign w_ge_rd   = r_ge;
`else
  logic w_unused_t1g;
  assign w_unused_t1g = t1g_n;
  assign w_enabled    = r_ton;
  assign w_ge_rd      = 1'b0;
`endif

  // Prescaler terminal count for the selected ratio
  always_comb begin
    w_term = '0;
    case (r_ckps)
      2'd0:    w_term = 3'd0;
      2'd1:    w_term = 3'd1;
      2'd2:    w_term = 3'd3;
      default: w_term = 3'd7;
    endcase
  end

  // Next counter/prescaler value; a byte load beats a coincident tick.
  // The >= compare lets a prescaler left above a newly shortened ratio roll over at once.
  always_comb begin
    w_cnt_nxt   = r_tmr1;
    w_presc_nxt = r_presc;
    w_ovf       = 1'b0;
    if (w_wr_l || w_wr_h) begin
      w_presc_nxt = '0;
      if (w_wr_l) w_cnt_nxt[7:0]  = data_in;
      if (w_wr_h) w_cnt_nxt[15:8] = data_in;
    end else if (instr_tick && w_enabled) begin
      if (r_presc >= w_term) begin
        w_presc_nxt = '0;
        w_cnt_nxt   = r_tmr1 + 16'd1;
        w_ovf       = (r_tmr1 == 16'hFFFF);
      end else begin
        w_presc_nxt = r_presc + 3'd1;
      end
    end
  end

  // Counter and prescaler state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr1  <= '0;
      r_presc <= '0;
    end else begin
      r_tmr1  <= w_cnt_nxt;
      r_presc <= w_presc_nxt;
    end
  end

  // T1CON fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ton  <= 1'b0;
      r_ckps <= 2'b00;
    end else if (w_wr_con) begin
      r_ton  <= data_in[0];
      r_ckps <= data_in[5:4];
    end
  end

  // Flag/enable pair; an overflow set beats a same-clk software write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if  <= 1'b0;
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_if  <= w_ovf || (w_wr_pir ? data_in[0] : r_if);
      if (w_wr_pie) r_ie <= data_in[0];
      r_irq <= r_if && r_ie;
    end
  end

  assign tmr1_irq = r_irq;

  // Combinational read mux and address decode
  always_comb begin
    data_out = 8'h00;
    addr_hit = 1'b0;
    case (addr)
      ADDR_TMR1L: begin data_out = r_tmr1[7:0];  addr_hit = 1'b1; end
      ADDR_TMR1H: begin data_out = r_tmr1[15:8]; addr_hit = 1'b1; end
      ADDR_T1CON: begin data_out = {1'b0, w_ge_rd, r_ckps, 3'b000, r_ton}; addr_hit = 1'b1; end
      ADDR_PIR1:  begin data_out = {7'b0, r_if}; addr_hit = 1'b1; end
      ADDR_PIE1:  begin data_out = {7'b0, r_ie}; addr_hit = 1'b1; end
      default:    begin data_out = 8'h00; addr_hit = 1'b0; end
    endcase
  end

endmodule

// File: tb/tb_pic_tmr1_peripheral.sv
// Bench for pic_tmr1_peripheral: vector table, directed corner sequences,
// and randomized traffic against a behavioural timer model.
module tb_pic_tmr1_peripheral;

  logic       clk;
  logic       rst_n;
  logic       instr_tick;
  logic [7:0] addr;
  logic       wr_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       addr_hit;
  logic       t1g_n;
  logic       tmr1_irq;

  int n_tests;
  int n_fail;

  pic_tmr1_peripheral dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_tick (instr_tick),
    .addr       (addr),
    .wr_en      (wr_en),
    .data_in    (data_in),
    .data_out   (data_out),
    .addr_hit   (addr_hit),
    .t1g_n      (t1g_n),
    .tmr1_irq   (tmr1_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef TMR1_GATE_EN
  localparam logic [7:0] T1CON_FF = 8'h71;
`else
  localparam logic [7:0] T1CON_FF = 8'h31;
`endif

  // Behavioural model: timer value, prescale phase within the ratio, flags
  int   m_cnt;
  int   m_phase;
  int   m_ckps;
  logic m_ton;
  logic m_ge;
  logic m_if;
  logic m_ie;
  logic m_irq;

  task automatic m_reset();
    m_cnt = 0; m_phase = 0; m_ckps = 0;
    m_ton = 1'b0; m_ge = 1'b0; m_if = 1'b0; m_ie = 1'b0; m_irq = 1'b0;
  endtask

  task automatic m_read(input logic [7:0] a, output logic [7:0] d, output logic h);
    h = 1'b1;
    case (a)
      8'h0E:   d = 8'(m_cnt);
      8'h0F:   d = 8'(m_cnt >> 8);
      8'h10:   d = {1'b0, m_ge, 2'(m_ckps), 3'b000, m_ton};
      8'h0C:   d = {7'b0, m_if};
      8'h8C:   d = {7'b0, m_ie};
      default: begin d = 8'h00; h = 1'b0; end
    endcase
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock with the given inputs; the model advances at the same edge
  task automatic step(input logic tk, input logic we, input logic [7:0] a, input logic [7:0] d);
    logic ovf;
    int   ratio;
    instr_tick = tk; wr_en = we; addr = a; data_in = d;
    @(posedge clk);
    ovf   = 1'b0;
    ratio = 1 << m_ckps;
    if (we && (a == 8'h0E || a == 8'h0F)) begin
      if (a == 8'h0E) m_cnt = (m_cnt & 32'hFF00) | int'(d);
      else            m_cnt = (m_cnt & 32'h00FF) | (int'(d) << 8);
      m_phase = 0;
    end else if (tk && m_ton) begin
      m_phase++;
      if (m_phase >= ratio) begin
        m_phase = 0;
        m_cnt++;
        if (m_cnt == 65536) begin m_cnt = 0; ovf = 1'b1; end
      end
    end
    m_irq = m_if & m_ie;
    if (we && a == 8'h10) begin
      m_ton  = d[0];
      m_ckps = int'(d[5:4]);
`ifdef TMR1_GATE_EN
      m_ge   = d[6];
`endif
    end
    if (we && a == 8'h0C) m_if = d[0];
    if (we && a == 8'h8C) m_ie = d[0];
    if (ovf) m_if = 1'b1;
    #1;
    instr_tick = 1'b0; wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic h);
    addr = a;
    #1;
    d = data_out;
    h = addr_hit;
  endtask

  typedef struct {
    logic       tk;
    logic       we;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] ra;
    logic [7:0] exp_d;
    logic       exp_hit;
    logic       exp_irq;
  } vec_t;

  vec_t       vecs[13];
  logic [7:0] addrs[5];

  initial begin
    logic [7:0] rdv;
    logic       rh;
    logic [7:0] md;
    logic       mh;

    n_tests = 0; n_fail = 0;
    instr_tick = 1'b0; wr_en = 1'b0; addr = 8'h00; data_in = 8'h00; t1g_n = 1'b0;
    addrs[0] = 8'h0E; addrs[1] = 8'h0F; addrs[2] = 8'h10; addrs[3] = 8'h0C; addrs[4] = 8'h8C;
    m_reset();

    // Overflow path, PIR1 clear, unmapped address, write-beats-tick, T1CON masking
    vecs[0]  = '{1'b0, 1'b1, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h0E, 8'hFE, 8'h0E, 8'hFE, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h10, 8'h01, 8'h10, 8'h01, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h8C, 8'hFF, 8'h8C, 8'h01, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h0E, 8'hFF, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h0F, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h0C, 8'h01, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 8'h0C, 8'h00, 8'h0C, 8'h00, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h0C, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h20, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'h0E, 8'h10, 8'h0E, 8'h10, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h0E, 8'h11, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'h10, 8'hFF, 8'h10, T1CON_FF, 1'b1, 1'b0};

    // Power-on reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd(addrs[i], rdv, rh);
      check($sformatf("reset_reg_%0h", addrs[i]), 16'(rdv), 16'h0000);
    end
    check("reset_irq", 16'(tmr1_irq), 16'h0000);

    // Vector table
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].tk, vecs[i].we, vecs[i].a, vecs[i].d);
      rd(vecs[i].ra, rdv, rh);
      check($sformatf("vec%0d_data", i), 16'(rdv), 16'(vecs[i].exp_d));
      check($sformatf("vec%0d_hit", i), 16'(rh), 16'(vecs[i].exp_hit));
      check($sformatf("vec%0d_irq", i), 16'(tmr1_irq), 16'(vecs[i].exp_irq));
    end

    // Asynchronous reset between edges with a loaded counter and pending irq
    step(1'b0, 1'b1, 8'h10, 8'h00);
    step(1'b0, 1'b1, 8'h0F, 8'h12);
    step(1'b0, 1'b1, 8'h0E, 8'h34);
    step(1'b0, 1'b1, 8'h8C, 8'h01);
    step(1'b0, 1'b1, 8'h0C, 8'h01);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    rd(8'h0E, rdv, rh);
    check("premid_tmr1l", 16'(rdv), 16'h0034);
    check("premid_irq", 16'(tmr1_irq), 16'h0001);
    rst_n = 1'b0;
    m_reset();
    for (int i = 0; i < 5; i++) begin
      rd(addrs[i], rdv, rh);
      check($sformatf("midrst_reg_%0h", addrs[i]), 16'(rdv), 16'h0000);
    end
    check("midrst_irq", 16'(tmr1_irq), 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1:8 prescaler and counter load mid-prescale
    step(1'b0, 1'b1, 8'h10, 8'h31);
    repeat (7) step(1'b1, 1'b0, 8'h00, 8'h00);
    rd(8'h0E, rdv, rh); check("ps8_7ticks", 16'(rdv), 16'h0000);
    step(1'b1, 1'b0, 8'h00, 8'h00);
    rd(8'h0E, rdv, rh); check("ps8_8ticks", 16'(rdv), 16'h0001);
    repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00);
    rd(8'h0E, rdv, rh); check("ps8_11ticks", 16'(rdv), 16'h0001);
    step(1'b1, 1'b1, 8'h0E, 8'h05);
    rd(8'h0E, rdv, rh); check("ps8_load5", 16'(rdv), 16'h0005);
    repeat (7) step(1'b1, 1'b0, 8'h00, 8'h00);
    rd(8'h0E, rdv, rh); check("ps8_load_7ticks", 16'(rdv), 16'h0005);
    step(1'b1, 1'b0, 8'h00, 8'h00);
    rd(8'h0E, rdv, rh); check("ps8_load_8ticks", 16'(rdv), 16'h0006);

    // PIR1 clear coinciding with overflow: set wins
    step(1'b0, 1'b1, 8'h10, 8'h01);
    step(1'b0, 1'b1, 8'h0F, 8'hFF);
    step(1'b0, 1'b1, 8'h0E, 8'hFF);
    step(1'b1, 1'b1, 8'h0C, 8'h00);
    rd(8'h0C, rdv, rh); check("pir1_set_wins", 16'(rdv), 16'h0001);
    rd(8'h0F, rdv, rh); check("ovf_wrap_h", 16'(rdv), 16'h0000);

    // Randomized traffic against the model
    for (int it = 0; it < 3000; it++) begin
      logic       tk;
      logic       we;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] ra;
      int         ai;
      tk = ($urandom_range(0, 99) < 60);
      we = ($urandom_range(0, 3) == 0);
      ai = $urandom_range(0, 5);
      a  = (ai == 5) ? 8'($urandom) : addrs[ai];
      d  = 8'($urandom);
      if (a == 8'h0F && $urandom_range(0, 1) == 1) d = 8'hFF;
      if (a == 8'h10) begin
        d[6] = 1'b0;
        d[0] = ($urandom_range(0, 3) != 0);
      end
      step(tk, we, a, d);
      ai = $urandom_range(0, 5);
      ra = (ai == 5) ? 8'($urandom) : addrs[ai];
      rd(ra, rdv, rh);
      m_read(ra, md, mh);
      check($sformatf("rnd%0d_data_%0h", it, ra), 16'(rdv), 16'(md));
      check($sformatf("rnd%0d_hit", it), 16'(rh), 16'(mh));
      check($sformatf("rnd%0d_irq", it), 16'(tmr1_irq), 16'(m_irq));
    end

`ifdef TMR1_GATE_EN
    // Gate held off, then released through the synchroniser
    t1g_n = 1'b1;
    step(1'b0, 1'b1, 8'h10, 8'h41);
    step(1'b0, 1'b1, 8'h0E, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    rd(8'h10, rdv, rh); check("gate_t1con", 16'(rdv), 16'h0041);
    repeat (5) step(1'b1, 1'b0, 8'h00, 8'h00);
    rd(8'h0E, rdv, rh); check("gate_closed", 16'(rdv), 16'h0000);
    t1g_n = 1'b0;
    step(1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h00);
    rd(8'h0E, rdv, rh); check("gate_open", 16'(rdv), 16'h0001);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
